// File: rtl/fb_writer_pkg.sv
// Shared frame-buffer definitions: image geometry, buffer address width and
// the writer state encoding. The matching/feature blocks import these too.
package fb_writer_pkg;

   localparam int IMG_W_DEF = 160;
   localparam int IMG_H_DEF = 120;
   localparam int FB_ADDR_W = 15;

   typedef logic [FB_ADDR_W-1:0] fb_addr_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2
   } fb_state_t;

   // Counter width for a 0..n-1 range. It never returns 0, so a dimension
   // of 1 still gets a legal 1-bit vector.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Raster position tracker for the frame writer. It holds the column, row and
// linear address of the next expected beat. The address only ever increments
// or reloads, so no multiplier is needed.
module fb_addr_gen
   import fb_writer_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF
)(
   input  logic     clock,
   input  logic     reset,
   input  logic     clear,      // back to the origin
   input  logic     restart,    // origin beat just written; point at position 1
   input  logic     inc,        // current position written; advance by one
   output fb_addr_t addr,
   output logic     at_origin,
   output logic     at_last
);

   localparam int COL_W = cnt_width(IMG_W);
   localparam int ROW_W = cnt_width(IMG_H);
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

   logic [COL_W-1:0] col_reg, col_next;
   logic [ROW_W-1:0] row_reg, row_next;
   fb_addr_t         addr_reg, addr_next;

   // Next position: clear wins over restart, and restart wins over increment.
   always_comb begin
      col_next  = col_reg;
      row_next  = row_reg;
      addr_next = addr_reg;
      if (clear) begin
         col_next  = '0;
         row_next  = '0;
         addr_next = '0;
      end else if (restart) begin
         addr_next = fb_addr_t'(1);
         if (IMG_W == 1) begin
            col_next = '0;
            row_next = ROW_W'(1);
         end else begin
            col_next = COL_W'(1);
            row_next = '0;
         end
      end else if (inc) begin
         addr_next = addr_reg + fb_addr_t'(1);
         if (col_reg == COL_MAX) begin
            col_next = '0;
            row_next = row_reg + ROW_W'(1);
         end else begin
            col_next = col_reg + COL_W'(1);
         end
      end
   end

   // Position registers. Reset returns them to the origin at once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         col_reg  <= '0;
         row_reg  <= '0;
         addr_reg <= '0;
      end else begin
         col_reg  <= col_next;
         row_reg  <= row_next;
         addr_reg <= addr_next;
      end
   end

   assign addr      = addr_reg;
   assign at_origin = (addr_reg == '0);
   assign at_last   = (col_reg == COL_MAX) && (row_reg == ROW_MAX);

endmodule

// File: rtl/fb_writer.sv
// Frame writer: it accepts a grey pixel stream, waits for start-of-frame and
// writes one complete frame into the external frame buffer. It then holds
// that frame, with the source stalled, until the consumer releases it.
// Every write is registered, so it is presented one cycle after its accept.
// IMG_W*IMG_H must not exceed 32768 so that every pixel has a buffer address.
module fb_writer
   import fb_writer_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF
)(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 pixValid,
   input  logic [7:0]           pixData,
   input  logic                 pixSof,
   output logic                 pixReady,
   input  logic                 frameRelease,
   output logic [FB_ADDR_W-1:0] FBAddr,
   output logic [7:0]           FBData,
   output logic                 FBwren,
   output logic                 frameDone,
   output logic                 sofErr
);

   // A one-pixel image finishes on its SOF beat.
   localparam bit SINGLE_PIX = (IMG_W * IMG_H == 1);

   fb_state_t state_reg, state_next;

   fb_addr_t   addr_reg, addr_next;
   logic [7:0] data_reg, data_next;
   logic       wren_reg, wren_next;
   logic       done_reg, done_next;
   logic       err_reg,  err_next;

   logic       accept;
   logic       gen_clear, gen_restart, gen_inc;
   fb_addr_t   gen_addr;
   logic       gen_at_origin, gen_at_last;

   assign pixReady = (state_reg != HOLD);
   assign accept   = pixValid && pixReady;

   fb_addr_gen #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) u_addr_gen (
      .clock     (clock),
      .reset     (reset),
      .clear     (gen_clear),
      .restart   (gen_restart),
      .inc       (gen_inc),
      .addr      (gen_addr),
      .at_origin (gen_at_origin),
      .at_last   (gen_at_last)
   );

   // Next state, write request and counter control for each accepted beat.
   always_comb begin
      state_next  = state_reg;
      addr_next   = addr_reg;
      data_next   = data_reg;
      wren_next   = 1'b0;
      done_next   = done_reg;
      err_next    = err_reg;
      gen_clear   = 1'b0;
      gen_restart = 1'b0;
      gen_inc     = 1'b0;
      case (state_reg)
         IDLE: begin
            // Beats before the first SOF are dropped without writing.
            if (accept && pixSof) begin
               wren_next = 1'b1;
               addr_next = '0;
               data_next = pixData;
               if (SINGLE_PIX) begin
                  state_next = HOLD;
                  done_next  = 1'b1;
                  gen_clear  = 1'b1;
               end else begin
                  state_next  = FILL;
                  gen_restart = 1'b1;
               end
            end
         end
         FILL: begin
            if (accept && pixSof) begin
               // A SOF in mid-frame is flagged; the new frame restarts at 0.
               if (!gen_at_origin) begin
                  err_next = 1'b1;
               end
               wren_next = 1'b1;
               addr_next = '0;
               data_next = pixData;
               if (SINGLE_PIX) begin
                  state_next = HOLD;
                  done_next  = 1'b1;
                  gen_clear  = 1'b1;
               end else begin
                  gen_restart = 1'b1;
               end
            end else if (accept) begin
               wren_next = 1'b1;
               addr_next = gen_addr;
               data_next = pixData;
               if (gen_at_last) begin
                  // Registered together with the last write, so frameDone
                  // rises in the same cycle that write is presented.
                  state_next = HOLD;
                  done_next  = 1'b1;
                  gen_clear  = 1'b1;
               end else begin
                  gen_inc = 1'b1;
               end
            end
         end
         HOLD: begin
            if (frameRelease) begin
               state_next = IDLE;
               done_next  = 1'b0;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Registered write port and status flags.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_reg <= '0;
         data_reg <= '0;
         wren_reg <= 1'b0;
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
      end else begin
         addr_reg <= addr_next;
         data_reg <= data_next;
         wren_reg <= wren_next;
         done_reg <= done_next;
         err_reg  <= err_next;
      end
   end

   assign FBAddr    = addr_reg;
   assign FBData    = data_reg;
   assign FBwren    = wren_reg;
   assign frameDone = done_reg;
   assign sofErr    = err_reg;

endmodule

// File: tb/tb_fb_writer.sv
// Bench for fb_writer. A frame-level reference model tracks the pixel index
// within the frame and the expected write for the next cycle. A short vector
// table and hand-written sequences cover the corner cases.
module tb_fb_writer;
   import fb_writer_pkg::*;

   localparam int W     = IMG_W_DEF;
   localparam int H     = IMG_H_DEF;
   localparam int TOTAL = W * H;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        pixValid = 1'b0;
   logic [7:0]  pixData = 8'h00;
   logic        pixSof = 1'b0;
   logic        pixReady;
   logic        frameRelease = 1'b0;
   logic [14:0] FBAddr;
   logic [7:0]  FBData;
   logic        FBwren;
   logic        frameDone;
   logic        sofErr;

   int vectors     = 0;
   int miscompares = 0;
   int wr_count    = 0;

   // Reference model state
   bit         m_hold, m_in_frame, m_err, m_done;
   int         m_idx;
   bit         e_wren;
   int         e_addr;
   logic [7:0] e_data;

   typedef struct {
      logic       v;
      logic       s;
      logic [7:0] d;
      logic       r;
      logic       ewren;
      int         eaddr;
      logic [7:0] edata;
      logic       eready;
      logic       edone;
   } vec_t;

   vec_t tbl[7];

   fb_writer dut (
      .clock        (clock),
      .reset        (reset),
      .pixValid     (pixValid),
      .pixData      (pixData),
      .pixSof       (pixSof),
      .pixReady     (pixReady),
      .frameRelease (frameRelease),
      .FBAddr       (FBAddr),
      .FBData       (FBData),
      .FBwren       (FBwren),
      .frameDone    (frameDone),
      .sofErr       (sofErr)
   );

   always #5 clock = ~clock;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   function automatic void model_reset();
      m_hold     = 0;
      m_in_frame = 0;
      m_err      = 0;
      m_done     = 0;
      m_idx      = 0;
      e_wren     = 0;
      e_addr     = 0;
      e_data     = 8'h00;
   endfunction

   function automatic void check_outputs();
      chk("wren", {31'd0, FBwren}, {31'd0, e_wren});
      if (e_wren) begin
         chk("addr", {17'd0, FBAddr}, e_addr);
         chk("data", {24'd0, FBData}, {24'd0, e_data});
      end
      chk("done", {31'd0, frameDone}, {31'd0, m_done});
      chk("sof_err", {31'd0, sofErr}, {31'd0, m_err});
      chk("ready", {31'd0, pixReady}, {31'd0, !m_hold});
      if (FBwren === 1'b1) wr_count++;
   endfunction

   // Drive one cycle of inputs (called just after a falling edge), update the
   // model, then check the outputs at the next falling edge.
   task automatic step(input logic v, input logic [7:0] d, input logic s, input logic r);
      bit old_hold;
      bit acc;
      pixValid     = v;
      pixData      = d;
      pixSof       = s;
      frameRelease = r;
      old_hold = m_hold;
      acc      = v && !m_hold;
      e_wren   = 0;
      if (acc) begin
         if (s) begin
            if (m_in_frame && m_idx != 0) m_err = 1;
            e_wren = 1; e_addr = 0; e_data = d;
            m_idx = 1; m_in_frame = 1;
         end else if (m_in_frame) begin
            e_wren = 1; e_addr = m_idx; e_data = d;
            m_idx++;
         end
         if (m_in_frame && m_idx == TOTAL) begin
            m_hold = 1; m_done = 1; m_in_frame = 0; m_idx = 0;
         end
      end
      if (r && old_hold) begin
         m_hold = 0;
         m_done = 0;
      end
      @(posedge clock);
      @(negedge clock);
      check_outputs();
   endtask

   // Assert reset between clock edges; the outputs must clear before any edge.
   task automatic do_reset();
      pixValid     = 0;
      pixSof       = 0;
      frameRelease = 0;
      #2 reset = 1'b1;
      #1;
      chk("rst_wren",  {31'd0, FBwren},    0);
      chk("rst_addr",  {17'd0, FBAddr},    0);
      chk("rst_data",  {24'd0, FBData},    0);
      chk("rst_done",  {31'd0, frameDone}, 0);
      chk("rst_err",   {31'd0, sofErr},    0);
      chk("rst_ready", {31'd0, pixReady},  1);
      model_reset();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      check_outputs();
   endtask

   initial begin
      // Beats without SOF are dropped; releases outside HOLD are ignored.
      tbl[0] = '{1'b1, 1'b0, 8'hAA, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 8'hBB, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 8'hCC, 1'b1, 1'b0, 0, 8'h00, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 0, 8'h11, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 8'h99, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 1, 8'h22, 1'b1, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 8'h33, 1'b0, 1'b1, 2, 8'h33, 1'b1, 1'b0};

      model_reset();
      do_reset();

      for (int i = 0; i < 7; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].r);
         chk($sformatf("tbl%0d_wren", i), {31'd0, FBwren}, {31'd0, tbl[i].ewren});
         if (tbl[i].ewren) begin
            chk($sformatf("tbl%0d_addr", i), {17'd0, FBAddr}, tbl[i].eaddr);
            chk($sformatf("tbl%0d_data", i), {24'd0, FBData}, {24'd0, tbl[i].edata});
         end
         chk($sformatf("tbl%0d_ready", i), {31'd0, pixReady}, {31'd0, tbl[i].eready});
         chk($sformatf("tbl%0d_done", i), {31'd0, frameDone}, {31'd0, tbl[i].edone});
      end

      // SOF at beat 500 of the frame in progress
      for (int i = 3; i < 500; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      step(1'b1, 8'h5A, 1'b1, 1'b0);
      chk("midsof_err",  {31'd0, sofErr}, 1);
      chk("midsof_addr", {17'd0, FBAddr}, 0);
      chk("midsof_data", {24'd0, FBData}, 8'h5A);
      step(1'b1, 8'h5B, 1'b0, 1'b0);
      chk("midsof_next_addr", {17'd0, FBAddr}, 1);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("midsof_err_sticky", {31'd0, sofErr}, 1);
      do_reset();

      // One full frame with data = address[7:0]
      wr_count = 0;
      step(1'b1, 8'h00, 1'b1, 1'b0);
      for (int i = 1; i < TOTAL; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("frame_last_addr", {17'd0, FBAddr}, TOTAL - 1);
      chk("frame_done",  {31'd0, frameDone}, 1);
      chk("frame_ready", {31'd0, pixReady}, 0);

      // HOLD with pixValid high: nothing written, then release
      for (int i = 0; i < 5; i++) step(1'b1, 8'hEE, 1'b0, 1'b0);
      chk("frame_writes", wr_count, TOTAL);
      step(1'b1, 8'hEE, 1'b0, 1'b1);
      chk("release_ready", {31'd0, pixReady}, 1);
      chk("release_done",  {31'd0, frameDone}, 0);
      step(1'b1, 8'hEF, 1'b0, 1'b0);
      chk("idle_no_write", {31'd0, FBwren}, 0);

      // Full frame with random gaps, random data and stray release pulses
      step(1'b1, 8'($urandom), 1'b1, 1'b0);
      for (int c = 0; c < 60000 && !m_hold; c++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'b0,
              1'($urandom_range(0, 15) == 0));
      end
      chk("rand_frame_done", {31'd0, frameDone}, 1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("rand_release_ready", {31'd0, pixReady}, 1);

      // Reset while address 7000 is being presented
      step(1'b1, 8'h00, 1'b1, 1'b0);
      for (int i = 1; i <= 7000; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("pre_reset_addr", {17'd0, FBAddr}, 7000);
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
      step(1'b1, 8'h42, 1'b1, 1'b0);
      chk("post_reset_addr", {17'd0, FBAddr}, 0);
      for (int i = 1; i < 20; i++) step(1'b1, 8'(i + 100), 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
